// File: rtl/rr_sel_arbiter.sv
// Eight-channel round-robin arbiter with hold-time limit; the granted index is
// exported as mux/demux select bits that stay put while idle.
module rr_sel_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LP_MAX_HOLD = 4'(MAX_HOLD);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_owner;
  logic [3:0] r_hcnt;
  logic [7:0] r_grant;
  logic       r_busy;

  logic       w_found;
  logic [2:0] w_pick;
  logic [2:0] w_idx;
  logic       w_release;

  // Search ptr, ptr+1, ... ptr+7 with 3-bit wraparound; first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_release = done | ~req[r_owner] | (r_hcnt == LP_MAX_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 3'd0;
      r_owner <= 3'd0;
      r_hcnt  <= 4'd0;
      r_grant <= 8'h00;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_owner <= w_pick;
            r_grant <= 8'b1 << w_pick;
            r_busy  <= 1'b1;
            r_hcnt  <= 4'd1;
          end
        end
        GRANT: begin
          // Owner index is kept on release so the select bits do not move.
          if (w_release) begin
            r_state <= IDLE;
            r_grant <= 8'h00;
            r_busy  <= 1'b0;
            r_hcnt  <= 4'd0;
            r_ptr   <= r_owner + 3'd1;
          end else begin
            r_hcnt  <= r_hcnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;
  assign sel0  = r_owner[0];
  assign sel1  = r_owner[1];
  assign sel2  = r_owner[2];

endmodule
